// File: rtl/mips_hazard_sequencer.sv
// Pipeline controller for the 5-stage MIPS datapath: ID decode, hazard stall/redirect,
// EX forwarding selects, boot/run/drain/halt sequencing and saturating perf counters.
module mips_hazard_sequencer #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_id,
    input  logic             eq_id,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dst,
    input  logic [4:0]       mem_dst,
    input  logic [4:0]       wb_dst,
    input  logic             ex_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             ex_memread,
    input  logic             mem_memread,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pc_src,
    output logic             if_id_flush,
    output logic             hazard_sel,
    output logic [8:0]       ctrl_word,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'b00,
        S_RUN    = 2'b01,
        S_DRAIN  = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam int SEQ_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam logic [SEQ_W-1:0] BOOT_LAST  = SEQ_W'(BOOT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           cur_state, nxt_state;
    logic [SEQ_W-1:0] seq_cnt, seq_nxt;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt;
    logic       known, uses_rt, is_beq, is_halt;
    logic       load_use, br_hazard, run, stall, taken, halt_go;

    assign opcode = instr_id[31:26];
    assign funct  = instr_id[5:0];
    assign rs     = instr_id[25:21];
    assign rt     = instr_id[20:16];

    always_comb begin
        ctrl_word = '0;
        known     = 1'b0;
        uses_rt   = 1'b0;
        is_beq    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            6'b000000: begin
                known        = 1'b1;
                uses_rt      = 1'b1;
                ctrl_word[0] = 1'b1;
                case (funct)
                    6'b100000: ctrl_word[4:2] = 3'b010;
                    6'b100010: ctrl_word[4:2] = 3'b110;
                    6'b100100: ctrl_word[4:2] = 3'b000;
                    6'b100101: ctrl_word[4:2] = 3'b001;
                    6'b101010: ctrl_word[4:2] = 3'b111;
                    default: begin
                        // Unknown funct (including the all-zero nop) behaves as a bubble.
                        known     = 1'b0;
                        uses_rt   = 1'b0;
                        ctrl_word = '0;
                    end
                endcase
            end
            6'b100011: begin
                known     = 1'b1;
                ctrl_word = 9'b1_0_1_1_010_1_1;
            end
            6'b101011: begin
                known     = 1'b1;
                uses_rt   = 1'b1;
                ctrl_word = 9'b0_1_1_0_010_0_0;
            end
            6'b001000: begin
                known     = 1'b1;
                ctrl_word = 9'b0_0_1_1_010_0_1;
            end
            6'b000100: begin
                known   = 1'b1;
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            6'b111111: begin
                known   = 1'b1;
                is_halt = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_use  = known & ex_memread & (ex_dst != 5'd0) &
                       ((ex_dst == rs) | (uses_rt & (ex_dst == rt)));
    assign br_hazard = is_beq &
                       ((ex_regwrite & (ex_dst != 5'd0) & ((ex_dst == rs) | (ex_dst == rt))) |
                        (mem_memread & (mem_dst != 5'd0) & ((mem_dst == rs) | (mem_dst == rt))));

    assign run     = (cur_state == S_RUN);
    assign stall   = run & (load_use | br_hazard);
    assign taken   = run & is_beq & eq_id & ~stall;
    assign halt_go = run & is_halt & ~stall;

    // The halt cycle freezes fetch so nothing younger than halt enters the pipe.
    always_comb begin
        pc_write    = run & ~stall & ~halt_go;
        if_id_write = run & ~stall & ~halt_go;
        hazard_sel  = run & ~stall & ~halt_go;
        pc_src      = taken;
        if_id_flush = taken;
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == src))
            return 2'b01;
        else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign forward_a = fwd_sel(ex_rs);
    assign forward_b = fwd_sel(ex_rt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_BOOT;
            seq_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            seq_cnt   <= seq_nxt;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        seq_nxt   = seq_cnt;
        case (cur_state)
            S_BOOT: begin
                if (seq_cnt == BOOT_LAST) begin
                    nxt_state = S_RUN;
                    seq_nxt   = '0;
                end else begin
                    seq_nxt = seq_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (halt_go) begin
                    nxt_state = S_DRAIN;
                    seq_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (seq_cnt == DRAIN_LAST) begin
                    nxt_state = S_HALTED;
                    seq_nxt   = '0;
                end else begin
                    seq_nxt = seq_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state = cur_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((cur_state == S_RUN || cur_state == S_DRAIN) && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mips_hazard_sequencer.sv
// Randomized bench for mips_hazard_sequencer against a cycle-level behavioural model,
// preceded by directed reset / load-use / forwarding / branch / halt / saturation cases.
module tb_mips_hazard_sequencer;

    localparam int BOOT_CYCLES  = 2;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CMAX         = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instr_id;
    logic             eq_id;
    logic [4:0]       ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic             ex_regwrite, mem_regwrite, wb_regwrite, ex_memread, mem_memread;
    logic             pc_write, if_id_write, pc_src, if_id_flush, hazard_sel;
    logic [8:0]       ctrl_word;
    logic [1:0]       forward_a, forward_b, state;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    mips_hazard_sequencer #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .eq_id(eq_id),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .mem_memread(mem_memread),
        .pc_write(pc_write), .if_id_write(if_id_write), .pc_src(pc_src),
        .if_id_flush(if_id_flush), .hazard_sel(hazard_sel), .ctrl_word(ctrl_word),
        .forward_a(forward_a), .forward_b(forward_b), .state(state),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: 0 BOOT, 1 RUN, 2 DRAIN, 3 HALTED; m_tick counts edges spent in BOOT/DRAIN.
    int m_state, m_tick, m_cyc, m_stl, m_fl;
    bit e_st, e_tk, e_hg;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d);
        return {6'b000000, s, t, d, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
        return {op, s, t, 16'h0040};
    endfunction

    function automatic void decode(input logic [31:0] ins, output logic [8:0] cw, output bit kn,
                                   output bit urt, output bit br, output bit hl);
        cw = 9'h000; kn = 1'b0; urt = 1'b0; br = 1'b0; hl = 1'b0;
        case (ins[31:26])
            6'h00: begin
                kn = 1'b1; urt = 1'b1;
                case (ins[5:0])
                    6'h20: cw = 9'h009;
                    6'h22: cw = 9'h019;
                    6'h24: cw = 9'h001;
                    6'h25: cw = 9'h005;
                    6'h2a: cw = 9'h01D;
                    default: begin kn = 1'b0; urt = 1'b0; end
                endcase
            end
            6'h23: begin kn = 1'b1; cw = 9'h16B; end
            6'h2b: begin kn = 1'b1; urt = 1'b1; cw = 9'h0C8; end
            6'h08: begin kn = 1'b1; cw = 9'h069; end
            6'h04: begin kn = 1'b1; urt = 1'b1; br = 1'b1; end
            6'h3f: begin kn = 1'b1; hl = 1'b1; end
            default: ;
        endcase
    endfunction

    function automatic int fwd(input logic [4:0] src);
        if (mem_regwrite && mem_dst != 0 && mem_dst == src) return 1;
        if (wb_regwrite && wb_dst != 0 && wb_dst == src) return 2;
        return 0;
    endfunction

    task automatic settle_check();
        logic [8:0] cw;
        bit kn, urt, br, hl, lu, bh, run, go;
        logic [4:0] s, t;
        #1;
        if (rst) begin
            m_state = 0; m_tick = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
        end
        decode(instr_id, cw, kn, urt, br, hl);
        s = instr_id[25:21];
        t = instr_id[20:16];
        lu = kn && ex_memread && ex_dst != 0 && (ex_dst == s || (urt && ex_dst == t));
        bh = br && ((ex_regwrite && ex_dst != 0 && (ex_dst == s || ex_dst == t)) ||
                    (mem_memread && mem_dst != 0 && (mem_dst == s || mem_dst == t)));
        run  = (m_state == 1);
        e_st = run && (lu || bh);
        e_tk = run && br && eq_id && !e_st;
        e_hg = run && hl && !e_st;
        go   = run && !e_st && !e_hg;
        check("state",       32'(state),       32'(m_state));
        check("ctrl_word",   32'(ctrl_word),   32'(cw));
        check("pc_write",    32'(pc_write),    32'(go));
        check("if_id_write", 32'(if_id_write), 32'(go));
        check("hazard_sel",  32'(hazard_sel),  32'(go));
        check("pc_src",      32'(pc_src),      32'(e_tk));
        check("if_id_flush", 32'(if_id_flush), 32'(e_tk));
        check("forward_a",   32'(forward_a),   32'(fwd(ex_rs)));
        check("forward_b",   32'(forward_b),   32'(fwd(ex_rt)));
        check("cycle_cnt",   32'(cycle_cnt),   32'(m_cyc));
        check("stall_cnt",   32'(stall_cnt),   32'(m_stl));
        check("flush_cnt",   32'(flush_cnt),   32'(m_fl));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (m_state == 1 || m_state == 2) m_cyc = sat(m_cyc + 1);
            if (e_st) m_stl = sat(m_stl + 1);
            if (e_tk) m_fl = sat(m_fl + 1);
            case (m_state)
                0: begin
                    m_tick++;
                    if (m_tick == BOOT_CYCLES) begin m_state = 1; m_tick = 0; end
                end
                1: if (e_hg) begin m_state = 2; m_tick = 0; end
                2: begin
                    m_tick++;
                    if (m_tick == DRAIN_CYCLES) begin m_state = 3; m_tick = 0; end
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic clear_pipe();
        instr_id = 32'h0; eq_id = 1'b0;
        ex_rs = 0; ex_rt = 0; ex_dst = 0; mem_dst = 0; wb_dst = 0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0; ex_memread = 0; mem_memread = 0;
    endtask

    task automatic reset_and_boot();
        rst = 1'b1;
        settle_check();
        advance();
        rst = 1'b0;
        for (int i = 0; i < BOOT_CYCLES; i++) begin
            settle_check();
            advance();
        end
    endtask

    task automatic rand_inputs();
        int k;
        logic [4:0] a, b, c;
        logic [5:0] fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        k = $urandom_range(0, 19);
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        case (k)
            0, 1, 2, 3, 4: instr_id = r_type(fns[$urandom_range(0, 4)], a, b, c);
            5, 6:          instr_id = i_type(6'h23, a, b);
            7:             instr_id = i_type(6'h2b, a, b);
            8:             instr_id = i_type(6'h08, a, b);
            9, 10, 11:     instr_id = i_type(6'h04, a, b);
            12:            instr_id = ($urandom_range(0, 3) == 0) ? i_type(6'h3f, a, b) : r_type(6'h20, a, b, c);
            13:            instr_id = 32'h0;
            14:            instr_id = $urandom;
            15:            instr_id = r_type(6'h3e, a, b, c);
            default:       instr_id = r_type(6'h20, a, b, c);
        endcase
        eq_id        = 1'($urandom_range(0, 1));
        ex_rs        = 5'($urandom_range(0, 3));
        ex_rt        = 5'($urandom_range(0, 3));
        ex_dst       = 5'($urandom_range(0, 3));
        mem_dst      = 5'($urandom_range(0, 3));
        wb_dst       = 5'($urandom_range(0, 3));
        ex_regwrite  = 1'($urandom_range(0, 1));
        mem_regwrite = 1'($urandom_range(0, 1));
        wb_regwrite  = 1'($urandom_range(0, 1));
        ex_memread   = ($urandom_range(0, 2) == 0);
        mem_memread  = ($urandom_range(0, 2) == 0);
        rst          = ($urandom_range(0, 39) == 0) || (m_state == 3 && $urandom_range(0, 3) == 0);
    endtask

    initial begin
        clear_pipe();
        m_state = 0; m_tick = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
        rst = 1'b1;
        @(negedge clk);

        // Reset and boot: fetch held for BOOT_CYCLES edges, then free-running.
        reset_and_boot();
        settle_check();
        check("boot_to_run", 32'(state), 32'd1);
        check("run_pc_write", 32'(pc_write), 32'd1);
        check("run_hazard_sel", 32'(hazard_sel), 32'd1);
        advance();

        // lw $2 in EX, add $3,$2,$4 in ID: one bubble.
        instr_id = r_type(6'h20, 5'd2, 5'd4, 5'd3);
        ex_memread = 1'b1; ex_dst = 5'd2;
        settle_check();
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_hazard_sel", 32'(hazard_sel), 32'd0);
        check("add_ctrl", 32'(ctrl_word), 32'h009);
        advance();
        ex_memread = 1'b0; ex_dst = 5'd0;
        settle_check();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu_resume", 32'(pc_write), 32'd1);
        advance();

        // Forwarding priority.
        ex_rs = 5'd5; mem_dst = 5'd5; mem_regwrite = 1'b1; wb_dst = 5'd5; wb_regwrite = 1'b1;
        settle_check();
        check("fwd_mem", 32'(forward_a), 32'd1);
        advance();
        mem_regwrite = 1'b0;
        settle_check();
        check("fwd_wb", 32'(forward_a), 32'd2);
        advance();
        ex_rs = 5'd0;
        settle_check();
        check("fwd_r0", 32'(forward_a), 32'd0);
        advance();
        clear_pipe();

        // beq taken, then beq behind an ALU producer: stall then redirect.
        instr_id = i_type(6'h04, 5'd1, 5'd2);
        eq_id = 1'b1;
        settle_check();
        check("beq_pc_src", 32'(pc_src), 32'd1);
        check("beq_flush", 32'(if_id_flush), 32'd1);
        advance();
        settle_check();
        check("beq_flush_cnt", 32'(flush_cnt), 32'd1);
        ex_dst = 5'd1; ex_regwrite = 1'b1;
        settle_check();
        check("beqh_pc_src", 32'(pc_src), 32'd0);
        check("beqh_pc_write", 32'(pc_write), 32'd0);
        advance();
        ex_dst = 5'd0; ex_regwrite = 1'b0;
        settle_check();
        check("beqh_redirect", 32'(pc_src), 32'd1);
        advance();
        clear_pipe();

        // Halt drains for DRAIN_CYCLES edges then parks in HALTED.
        instr_id = i_type(6'h3f, 5'd0, 5'd0);
        settle_check();
        check("halt_pc_write", 32'(pc_write), 32'd0);
        advance();
        instr_id = 32'h0;
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            settle_check();
            check("drain_state", 32'(state), 32'd2);
            check("drain_pc_write", 32'(pc_write), 32'd0);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            settle_check();
            check("halted_state", 32'(state), 32'd3);
            advance();
        end

        // Continuous load-use stalls saturate stall_cnt.
        reset_and_boot();
        instr_id = r_type(6'h20, 5'd2, 5'd4, 5'd3);
        ex_memread = 1'b1; ex_dst = 5'd2;
        for (int i = 0; i < 20; i++) begin
            settle_check();
            advance();
        end
        settle_check();
        check("stall_sat", 32'(stall_cnt), 32'(CMAX));
        clear_pipe();
        reset_and_boot();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            settle_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
